// File: rtl/drv_tx_pkg.sv
// Shared types and helpers for the transmit scheduler.
// Holds the control-state encoding and the requester-index width rule.
package drv_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Index width never drops below one bit, so NREQ=1 still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drv_tx_rr_arbiter.sv
// Combinational round-robin picker.
// Chooses the lowest requesting index at or above ptr, wrapping to 0.
module drv_tx_rr_arbiter
  import drv_tx_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  gnt_idx
);

  localparam int IW = idx_w(NREQ);

  logic            found;
  logic [NREQ-1:0] sel;

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    gnt_idx = '0;
    // First pass covers [ptr, NREQ-1]; the second pass supplies the wrap.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    gnt = en ? sel : '0;
  end

endmodule

// File: rtl/drv_tx_scheduler.sv
// Shares one UART-style serial line among NREQ byte requesters.
// Frames are start bit, DATA_W bits LSB first, one stop bit.
module drv_tx_scheduler
  import drv_tx_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     done
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [IW-1:0]     ptr_q, ptr_d, grant_q, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [BW-1:0]     baud_q, baud_d;
  logic [CW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q, busy_q, done_q;
  logic              accept, bit_end;

  drv_tx_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign baud_d    = bit_end ? '0 : baud_q + BW'(1);
  assign ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (accept) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            grant_q <= gnt_idx;
            ptr_q   <= ptr_d;
          end
        end
        START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (bit_q == CW'(DATA_W - 1)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q  <= shift_q[0];
              bit_q <= bit_q + CW'(1);
            end
          end
        end
        STOP: begin
          baud_q <= baud_d;
          // Registered, so raise it one cycle early to land on the final stop cycle.
          if (baud_q == BW'(CLKS_PER_BIT - 2)) done_q <= 1'b1;
          if (bit_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data path: loaded on accept, shifted at each bit boundary; no reset needed.
  always_ff @(posedge clk) begin
    if (accept)
      shift_q <= req_data[gnt_idx*DATA_W +: DATA_W];
    else if ((state_q == START || state_q == DATA) && bit_end)
      shift_q <= shift_q >> 1;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_drv_tx_scheduler.sv
// Directed bench for drv_tx_scheduler with NREQ=4, DATA_W=8, CLKS_PER_BIT=4.
module tb_drv_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx, busy, done;
  logic [1:0]        grant_id;

  int vec_n  = 0;
  int miss_n = 0;

  drv_tx_scheduler #(.NREQ(NREQ), .DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [3:0] exp_ready;
    logic [9:0] exp_frame;  // bit 0 is the first bit on the wire
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one byte, check acceptance, then sample the whole frame.
  // Data is overwritten with 0xFF right after acceptance to prove it was latched.
  task automatic run_frame(input vec_t v);
    logic [9:0] got;
    int unstable, busy_bad, done_at, done_cnt;
    @(negedge clk);
    req_data[v.id*DW +: DW] = v.data;
    req_valid = 4'(1 << v.id);
    #1;
    chk("ready_onehot", 32'(req_ready), 32'(v.exp_ready));
    got = '0; unstable = 0; busy_bad = 0; done_at = -1; done_cnt = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = '0;
        req_data[v.id*DW +: DW] = 8'hFF;
        chk("grant_id", 32'(grant_id), 32'(v.exp_gid));
      end
      if ((c - 1) % CPB == 0) got[(c-1)/CPB] = tx;
      else if (tx !== got[(c-1)/CPB]) unstable++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
    end
    chk("frame_bits", 32'(got), 32'(v.exp_frame));
    chk("bit_hold", unstable, 0);
    chk("busy_in_frame", busy_bad, 0);
    chk("done_count", done_cnt, 1);
    chk("done_at", done_at, FRAME);
    @(negedge clk);
    chk("idle_tx", 32'(tx), 1);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin : main
    int bad;
    int acc_cyc[5];
    int acc_id[5];
    int exp_order[5];
    int n, cyc, idle_hi, rdy_bad, busy_bad, done_cnt;

    vecs[0] = '{2, 8'hA5, 4'b0100, 10'b1101001010, 2'd2};
    vecs[1] = '{0, 8'h00, 4'b0001, 10'b1000000000, 2'd0};
    vecs[2] = '{3, 8'hFF, 4'b1000, 10'b1111111110, 2'd3};
    vecs[3] = '{1, 8'h3C, 4'b0010, 10'b1001111000, 2'd1};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset values while rst_n is low
    @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Round robin with all four holding valid
    do_reset();
    @(negedge clk);
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    n = 0; cyc = 0; idle_hi = 0;
    while (n < 5 && cyc < 400) begin
      #1;
      if (busy === 1'b0 && tx === 1'b1) idle_hi++;
      if (req_ready !== 4'b0) begin
        acc_cyc[n] = cyc;
        acc_id[n]  = oh_idx(req_ready);
        chk("rr_order", acc_id[n], exp_order[n]);
        if (n > 0) begin
          chk("rr_period", acc_cyc[n] - acc_cyc[n-1], FRAME + 1);
          chk("rr_idle_gap", idle_hi, 1);
        end
        idle_hi = 0;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("rr_accepts", n, 5);
    chk("rr_grant_id", 32'(grant_id), 0);

    cyc = 0;
    while (busy !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rr_drain", 32'(busy), 0);

    // Late request from req 1 withdrawn before its chance
    @(negedge clk);
    req_data[7:0] = 8'h55;
    req_valid = 4'b0001;
    #1;
    chk("late_accept0", 32'(req_ready), 32'(4'b0001));
    rdy_bad = 0; busy_bad = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == 1)  req_valid[0] = 1'b0;
      if (c == 10) req_valid[1] = 1'b1;
      if (c == 30) req_valid[1] = 1'b0;
      #1;
      if (req_ready !== 4'b0) rdy_bad++;
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) rdy_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    chk("late_no_ready", rdy_bad, 0);
    chk("late_no_frame", busy_bad, 0);

    // Reset in the middle of the data phase
    @(negedge clk);
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = '0;
    end
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done !== 1'b0) done_cnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 0);
    req_data[31:24] = 8'h77;
    req_data[7:0]   = 8'h11;
    req_valid = 4'b1001;
    #1;
    chk("post_rst_ptr", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    chk("post_rst_gid", 32'(grant_id), 0);
    chk("post_rst_busy", 32'(busy), 1);
    repeat (FRAME + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
